// File: rtl/debug_dump_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debug_dump_tx_pkg
//  Description : Shared widths, frame layout and state encoding for the
//                debug dump transmit sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package debug_dump_tx_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int DATA_WIDTH_UART = 8;
    localparam int N_REGS          = 32;
    localparam int N_MEM           = 32;
    localparam int ADDR_WIDTH      = 5;
    localparam int WIDX_WIDTH      = 7;
    localparam int BIDX_WIDTH      = 2;

    // Frame layout: word 0 is the PC, then registers, then memory words.
    localparam logic [WIDX_WIDTH-1:0] PC_WORD   = 7'd0;
    localparam logic [WIDX_WIDTH-1:0] REG_BASE  = 7'd1;
    localparam logic [WIDX_WIDTH-1:0] MEM_BASE  = 7'd33;
    localparam logic [WIDX_WIDTH-1:0] LAST_WORD = 7'd64;
    localparam int                    BYTES_PER_WORD = 4;
    localparam logic [BIDX_WIDTH-1:0] LAST_BYTE = BIDX_WIDTH'(BYTES_PER_WORD - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ADDR  = ST_ADDR,
        S_LATCH = ST_LATCH,
        S_SEND  = ST_SEND,
        S_WAIT  = ST_WAIT,
        S_DONE  = ST_DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/debug_dump_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : debug_dump_tx_if
//  Description : Debug read ports, UART byte handshake and status of the
//                debug dump transmit sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface debug_dump_tx_if;
    import debug_dump_tx_pkg::*;

    logic                       i_start;
    logic [DATA_WIDTH-1:0]      i_pc;
    logic [ADDR_WIDTH-1:0]      o_reg_addr;
    logic [DATA_WIDTH-1:0]      i_reg_data;
    logic [ADDR_WIDTH-1:0]      o_mem_addr;
    logic [DATA_WIDTH-1:0]      i_mem_data;
    logic                       i_tx_available;
    logic                       i_tx_done;
    logic [DATA_WIDTH_UART-1:0] o_tx_byte;
    logic                       o_tx_signal;
    logic                       o_busy;
    logic                       o_done;

    modport master (
        input  i_start, i_pc, i_reg_data, i_mem_data, i_tx_available, i_tx_done,
        output o_reg_addr, o_mem_addr, o_tx_byte, o_tx_signal, o_busy, o_done
    );

    modport slave (
        output i_start, i_pc, i_reg_data, i_mem_data, i_tx_available, i_tx_done,
        input  o_reg_addr, o_mem_addr, o_tx_byte, o_tx_signal, o_busy, o_done
    );

endinterface
`default_nettype wire

// File: rtl/debug_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : debug_dump_tx
//  Description : Serializes PC, register file and data memory to the UART,
//                one byte per handshake, least-significant byte first.
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_dump_tx
    import debug_dump_tx_pkg::*;
(
    input  wire logic       i_clock,
    input  wire logic       i_reset,
    debug_dump_tx_if.master bus
);

    state_t                     r_state,      w_state_nxt;
    logic [DATA_WIDTH-1:0]      r_word,       w_word_nxt;
    logic [WIDX_WIDTH-1:0]      r_word_idx,   w_word_idx_nxt;
    logic [BIDX_WIDTH-1:0]      r_byte_idx,   w_byte_idx_nxt;
    logic [ADDR_WIDTH-1:0]      r_reg_addr,   w_reg_addr_nxt;
    logic [ADDR_WIDTH-1:0]      r_mem_addr,   w_mem_addr_nxt;
    logic [DATA_WIDTH_UART-1:0] r_tx_byte,    w_tx_byte_nxt;
    logic                       r_tx_signal,  w_tx_signal_nxt;
    logic                       r_busy,       w_busy_nxt;
    logic                       r_done,       w_done_nxt;

    logic [WIDX_WIDTH-1:0]      w_word_idx_inc;
    logic [WIDX_WIDTH-1:0]      w_reg_off;
    logic [WIDX_WIDTH-1:0]      w_mem_off;

    assign w_word_idx_inc = r_word_idx + 7'd1;
    assign w_reg_off      = w_word_idx_inc - REG_BASE;
    assign w_mem_off      = w_word_idx_inc - MEM_BASE;

    always_comb begin
        w_state_nxt     = r_state;
        w_word_nxt      = r_word;
        w_word_idx_nxt  = r_word_idx;
        w_byte_idx_nxt  = r_byte_idx;
        w_reg_addr_nxt  = r_reg_addr;
        w_mem_addr_nxt  = r_mem_addr;
        w_tx_byte_nxt   = r_tx_byte;
        w_tx_signal_nxt = 1'b0;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_word_nxt     = bus.i_pc;
                    w_word_idx_nxt = PC_WORD;
                    w_byte_idx_nxt = '0;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = S_SEND;
                end
            end
            S_ADDR: begin
                w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_word_nxt     = (r_word_idx < MEM_BASE) ? bus.i_reg_data : bus.i_mem_data;
                w_byte_idx_nxt = '0;
                w_state_nxt    = S_SEND;
            end
            S_SEND: begin
                if (bus.i_tx_available) begin
                    w_tx_signal_nxt = 1'b1;
                    w_tx_byte_nxt   = r_word[{r_byte_idx, 3'b000} +: DATA_WIDTH_UART];
                    w_state_nxt     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.i_tx_done) begin
                    if (r_byte_idx != LAST_BYTE) begin
                        w_byte_idx_nxt = r_byte_idx + 2'd1;
                        w_state_nxt    = S_SEND;
                    end else if (r_word_idx == LAST_WORD) begin
                        w_state_nxt    = S_DONE;
                    end else begin
                        // Addresses are issued on entry to ADDR so the
                        // synchronous memory has its data ready in LATCH.
                        w_word_idx_nxt = w_word_idx_inc;
                        w_state_nxt    = S_ADDR;
                        if (w_word_idx_inc < MEM_BASE) begin
                            w_reg_addr_nxt = w_reg_off[ADDR_WIDTH-1:0];
                        end else begin
                            w_mem_addr_nxt = w_mem_off[ADDR_WIDTH-1:0];
                        end
                    end
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_word      <= '0;
            r_word_idx  <= '0;
            r_byte_idx  <= '0;
            r_reg_addr  <= '0;
            r_mem_addr  <= '0;
            r_tx_byte   <= '0;
            r_tx_signal <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_word      <= w_word_nxt;
            r_word_idx  <= w_word_idx_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            r_reg_addr  <= w_reg_addr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_tx_byte   <= w_tx_byte_nxt;
            r_tx_signal <= w_tx_signal_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bus.o_reg_addr  = r_reg_addr;
    assign bus.o_mem_addr  = r_mem_addr;
    assign bus.o_tx_byte   = r_tx_byte;
    assign bus.o_tx_signal = r_tx_signal;
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_debug_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_dump_tx
//  Description : Randomized bench for debug_dump_tx with a UART responder and
//                a frame-level byte model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_debug_dump_tx;
    import debug_dump_tx_pkg::*;

    localparam int c_FRAME = 260;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    debug_dump_tx_if bus();

    debug_dump_tx dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    logic [31:0] regs [N_REGS];
    logic [31:0] mem  [N_MEM];
    logic [31:0] pc_m;
    logic [31:0] mem_q;
    logic        uart_done  = 1'b0;
    logic        uart_avail = 1'b1;
    logic        uart_busy  = 1'b0;
    logic        stall      = 1'b0;
    logic        spur_done  = 1'b0;

    assign bus.i_reg_data     = regs[bus.o_reg_addr];
    assign bus.i_mem_data     = mem_q;
    assign bus.i_tx_available = uart_avail & ~stall;
    assign bus.i_tx_done      = uart_done | spur_done;

    always @(posedge clk) mem_q <= mem[bus.o_mem_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Byte k of the frame: word k/4, byte k%4 of that word.
    function automatic logic [7:0] frame_byte(input int k);
        logic [31:0] w;
        int wi;
        wi = k / 4;
        if (wi == 0)       w = pc_m;
        else if (wi <= 32) w = regs[wi - 1];
        else               w = mem[wi - 33];
        w = w >> (8 * (k % 4));
        return w[7:0];
    endfunction

    int          cnt      = 0;
    int          done_cnt = 0;
    int          cyc      = 0;
    int          last_done_cyc = 0;
    int          delay    = 0;
    logic        clean    = 1'b0;
    logic        prev_busy = 1'b0;
    logic        prev_ok  = 1'b0;
    logic [7:0]  prev_byte = 8'h00;
    logic [7:0]  got [c_FRAME];

    // UART responder plus per-cycle comparison against the frame model.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                uart_busy  = 1'b0;
                uart_done  = 1'b0;
                uart_avail = 1'b1;
                clean      = 1'b0;
                prev_ok    = 1'b0;
                prev_busy  = 1'b0;
            end else begin
                if (!bus.i_tx_available) clean = 1'b0;
                if (bus.o_busy && !prev_busy) cnt = 0;
                if (prev_busy && !bus.o_busy) check("busy_fall_with_done", bus.o_done, 1);
                if (prev_ok && !bus.o_tx_signal) check("byte_hold", bus.o_tx_byte, prev_byte);
                uart_done = 1'b0;
                if (bus.o_tx_signal) begin
                    check("signal_when_avail", bus.i_tx_available, 1);
                    check("signal_while_busy", bus.o_busy, 1);
                    if (cnt < c_FRAME) begin
                        check($sformatf("byte%0d", cnt), bus.o_tx_byte, frame_byte(cnt));
                        got[cnt] = bus.o_tx_byte;
                        if (cnt > 0 && clean)
                            check($sformatf("gap%0d", cnt), cyc - last_done_cyc, (cnt % 4 == 0) ? 4 : 2);
                    end else begin
                        check("overrun", cnt, c_FRAME - 1);
                    end
                    cnt++;
                    uart_busy  = 1'b1;
                    uart_avail = 1'b0;
                    delay      = $urandom_range(1, 5);
                end else if (uart_busy) begin
                    if (delay > 1) begin
                        delay--;
                    end else begin
                        uart_done     = 1'b1;
                        uart_avail    = 1'b1;
                        uart_busy     = 1'b0;
                        last_done_cyc = cyc;
                        clean         = 1'b1;
                    end
                end
                if (bus.o_done) begin
                    done_cnt++;
                    check("done_byte_count", cnt, c_FRAME);
                    check("done_busy_low", bus.o_busy, 0);
                    if (clean) check("done_latency", cyc - last_done_cyc, 2);
                end
                prev_busy = bus.o_busy;
                prev_byte = bus.o_tx_byte;
                prev_ok   = 1'b1;
            end
        end
    end

    task automatic randomize_state();
        for (int k = 0; k < 32; k++) begin
            regs[k] = $urandom;
            mem[k]  = $urandom;
        end
        pc_m = $urandom;
    endtask

    task automatic pulse_start(input logic [31:0] pc, input logic expect_rise);
        @(negedge clk);
        #1;
        bus.i_pc    = pc;
        bus.i_start = 1'b1;
        @(negedge clk);
        if (expect_rise) check("busy_rise", bus.o_busy, 1);
        #1;
        bus.i_start = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 5000 && cnt < n; i++) @(negedge clk);
        check("reach_byte", (cnt >= n) ? 32'd1 : 32'd0, 1);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 20000 && done_cnt < target; i++) @(negedge clk);
        check("dump_complete", done_cnt, target);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_byte"},   bus.o_tx_byte,   0);
        check({tag, "_tx_signal"}, bus.o_tx_signal, 0);
        check({tag, "_busy"},      bus.o_busy,      0);
        check({tag, "_done"},      bus.o_done,      0);
        check({tag, "_reg_addr"},  bus.o_reg_addr,  0);
        check({tag, "_mem_addr"},  bus.o_mem_addr,  0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_pc    = '0;
        for (int k = 0; k < 32; k++) begin
            regs[k] = k;
            mem[k]  = 32'h100 + k;
        end
        pc_m = 32'h0000_0040;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        #1 rst_n = 1'b1;

        // Spurious tx_done while idle must not start anything.
        @(negedge clk); #1 spur_done = 1'b1;
        @(negedge clk); #1 spur_done = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_spurious_busy", bus.o_busy, 0);

        // Dump 1: known contents.
        pulse_start(pc_m, 1'b1);
        wait_done(1);
        check("t1_b0", got[0], 8'h40);
        check("t1_b1", got[1], 8'h00);
        check("t1_b3", got[3], 8'h00);
        check("t1_b4", got[4], 8'h00);
        check("t1_b8", got[8], 8'h01);
        check("t1_b9", got[9], 8'h00);
        check("t1_b132", got[132], 8'h00);
        check("t1_b133", got[133], 8'h01);

        // Dump 2: random contents, boundary words, mid-frame stall.
        randomize_state();
        regs[31] = 32'hDEAD_BEEF;
        mem[31]  = 32'hCAFE_F00D;
        pulse_start(pc_m, 1'b1);
        wait_bytes(100);
        #1 stall = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 50 && uart_busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #1 spur_done = 1'b1;
        @(negedge clk); #1 spur_done = 1'b0;
        repeat (44) @(negedge clk);
        #1 stall = 1'b0;
        wait_done(2);
        check("t2_b128", got[128], 8'hEF);
        check("t2_b129", got[129], 8'hBE);
        check("t2_b130", got[130], 8'hAD);
        check("t2_b131", got[131], 8'hDE);
        check("t2_b256", got[256], 8'h0D);
        check("t2_b257", got[257], 8'hF0);
        check("t2_b258", got[258], 8'hFE);
        check("t2_b259", got[259], 8'hCA);

        // Dump 3: second start mid-frame is dropped.
        randomize_state();
        pulse_start(pc_m, 1'b1);
        wait_bytes(10);
        pulse_start(~pc_m, 1'b0);
        wait_done(3);
        repeat (20) @(negedge clk);
        check("t3_single_done", done_cnt, 3);
        check("t3_not_queued", bus.o_busy, 0);

        // Dump 4: reset during word 20, then a clean restart.
        randomize_state();
        pulse_start(pc_m, 1'b1);
        wait_bytes(80);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t4_no_done_after_reset", done_cnt, 3);
        check("t4_idle_after_reset", bus.o_busy, 0);
        randomize_state();
        pulse_start(pc_m, 1'b1);
        wait_done(4);
        check("t4_restart_b0", got[0], pc_m[7:0]);
        check("t4_restart_b1", got[1], pc_m[15:8]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
